// File: rtl/voice_mixer.sv
// Frame mixer: sums one sample per voice across a frame, scales and saturates
// the frame sum, and hands it downstream over a valid/ready register.
module voice_mixer #(
    parameter int SAMPLE_W   = 16,
    parameter int NUM_VOICES = 256,
    parameter int ACC_W      = 24,
    parameter int OUT_SHIFT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic [7:0]          in_voice,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                overrun,
    output logic                seq_error,
    output logic [15:0]         frame_count
);

    typedef enum logic {SYNC, RUN} state_t;

    localparam logic [7:0] LAST_VOICE = 8'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    state_t                    state_reg, state_next;
    logic signed [ACC_W-1:0]   acc_reg, acc_next;
    logic [7:0]                expected_reg, expected_next;
    logic                      frame_done;
    logic                      seq_err_set;

    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic [SAMPLE_W-1:0]       result;

    assign sample_ext = {{(ACC_W-SAMPLE_W){in_sample[SAMPLE_W-1]}}, in_sample};
    assign sum        = acc_reg + sample_ext;
    assign shifted    = sum >>> OUT_SHIFT;

    always_comb begin
        if (shifted > SAT_MAX)
            result = SAT_MAX[SAMPLE_W-1:0];
        else if (shifted < SAT_MIN)
            result = SAT_MIN[SAMPLE_W-1:0];
        else
            result = shifted[SAMPLE_W-1:0];
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        expected_next = expected_reg;
        frame_done    = 1'b0;
        seq_err_set   = 1'b0;
        if (in_valid) begin
            case (state_reg)
                SYNC: begin
                    if (in_voice == 8'd0) begin
                        acc_next      = sample_ext;
                        expected_next = 8'd1;
                        state_next    = RUN;
                    end
                end
                RUN: begin
                    if (in_voice == expected_reg) begin
                        if (in_voice == LAST_VOICE) begin
                            frame_done    = 1'b1;
                            acc_next      = '0;
                            expected_next = 8'd0;
                            state_next    = SYNC;
                        end else begin
                            acc_next      = sum;
                            expected_next = expected_reg + 8'd1;
                        end
                    end else begin
                        seq_err_set = 1'b1;
                        // A stray voice 0 is itself a valid frame start.
                        if (in_voice == 8'd0) begin
                            acc_next      = sample_ext;
                            expected_next = 8'd1;
                            state_next    = RUN;
                        end else begin
                            acc_next      = '0;
                            expected_next = 8'd0;
                            state_next    = SYNC;
                        end
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= SYNC;
            acc_reg      <= '0;
            expected_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            expected_reg <= expected_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_sample  <= '0;
            overrun     <= 1'b0;
            seq_error   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            overrun <= 1'b0;
            if (seq_err_set)
                seq_error <= 1'b1;
            if (frame_done) begin
                out_sample  <= result;
                out_valid   <= 1'b1;
                frame_count <= frame_count + 16'd1;
                overrun     <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: frame mixing, saturation/floor, sequencing
// errors, overrun, mid-frame reset and gapped beats with handshake at completion.
module tb_voice_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_sample;
    logic [7:0]  in_voice;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic        overrun;
    logic        seq_error;
    logic [15:0] frame_count;

    int n_vec = 0;
    int n_err = 0;

    voice_mixer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sample   (in_sample),
        .in_voice    (in_voice),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sample  (out_sample),
        .overrun     (overrun),
        .seq_error   (seq_error),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic [7:0] v, input logic [15:0] s);
        in_valid  = 1'b1;
        in_voice  = v;
        in_sample = s;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_voice  = 8'hAA;
        in_sample = 16'hDEAD;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] s);
        for (int v = 0; v < 256; v++)
            beat(8'(v), s);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(1);
        n_vec++;
        if ({out_valid, out_sample, overrun, seq_error, frame_count} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b sample=%h ovr=%b seq=%b fc=%0d, all zero required",
                     out_valid, out_sample, overrun, seq_error, frame_count);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_basic_frame;
        out_ready = 1'b1;
        send_frame(16'h0100);
        n_vec++;
        if (out_valid !== 1'b1 || out_sample !== 16'h1000 || frame_count !== 16'd1) begin
            n_err++;
            $display("FAIL basic_frame: valid=%b sample=%h fc=%0d, required 1 1000 1",
                     out_valid, out_sample, frame_count);
        end
        $display("basic_frame: sample=%h fc=%0d", out_sample, frame_count);
        idle(1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_saturation;
        send_frame(16'h7FFF);
        n_vec++;
        if (out_sample !== 16'h7FFF || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL sat_pos: sample=%h ovr=%b, required 7fff 0", out_sample, overrun);
        end
        $display("sat_pos: sample=%h", out_sample);
        send_frame(16'h8000);
        n_vec++;
        if (out_sample !== 16'h8000 || frame_count !== 16'd3) begin
            n_err++;
            $display("FAIL sat_neg: sample=%h fc=%0d, required 8000 3", out_sample, frame_count);
        end
        $display("sat_neg: sample=%h", out_sample);
        // -1 >>> 4 must floor to -1, not truncate to 0.
        beat(8'd0, 16'hFFFF);
        for (int v = 1; v < 256; v++)
            beat(8'(v), 16'h0000);
        n_vec++;
        if (out_sample !== 16'hFFFF) begin
            n_err++;
            $display("FAIL floor_minus1: sample=%h, required ffff", out_sample);
        end
        $display("floor_minus1: sample=%h", out_sample);
        send_frame(16'hFFFF);
        n_vec++;
        if (out_sample !== 16'hFFF0 || frame_count !== 16'd5) begin
            n_err++;
            $display("FAIL floor_all_neg1: sample=%h fc=%0d, required fff0 5", out_sample, frame_count);
        end
        $display("floor_all_neg1: sample=%h", out_sample);
        idle(1);
    endtask

    task automatic test_seq_error;
        n_vec++;
        if (seq_error !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL seq_pre: seq=%b valid=%b, required 0 0", seq_error, out_valid);
        end
        for (int v = 0; v < 10; v++)
            beat(8'(v), 16'h0100);
        beat(8'd11, 16'h0100);
        n_vec++;
        if (seq_error !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL seq_skip: seq=%b valid=%b, required 1 0", seq_error, out_valid);
        end
        $display("seq_skip: seq=%b", seq_error);
        // Finish the broken frame: all beats ignored while resynchronising.
        for (int v = 12; v < 256; v++)
            beat(8'(v), 16'h0100);
        n_vec++;
        if (out_valid !== 1'b0 || frame_count !== 16'd5) begin
            n_err++;
            $display("FAIL seq_ignored: valid=%b fc=%0d, required 0 5", out_valid, frame_count);
        end
        // Partial junk frame, then an out-of-order voice 0 restarts cleanly.
        for (int v = 0; v < 50; v++)
            beat(8'(v), 16'h7FFF);
        send_frame(16'h0010);
        n_vec++;
        if (out_valid !== 1'b1 || out_sample !== 16'h0100 || seq_error !== 1'b1 ||
            frame_count !== 16'd6) begin
            n_err++;
            $display("FAIL seq_recover: valid=%b sample=%h seq=%b fc=%0d, required 1 0100 1 6",
                     out_valid, out_sample, seq_error, frame_count);
        end
        $display("seq_recover: sample=%h seq=%b", out_sample, seq_error);
        idle(1);
    endtask

    task automatic test_overrun;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        out_ready = 1'b0;
        send_frame(16'h0100);
        n_vec++;
        if (out_valid !== 1'b1 || overrun !== 1'b0 || out_sample !== 16'h1000) begin
            n_err++;
            $display("FAIL ovr_first: valid=%b ovr=%b sample=%h, required 1 0 1000",
                     out_valid, overrun, out_sample);
        end
        send_frame(16'h0200);
        n_vec++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out_sample !== 16'h2000 ||
            frame_count !== 16'd2) begin
            n_err++;
            $display("FAIL ovr_second: ovr=%b valid=%b sample=%h fc=%0d, required 1 1 2000 2",
                     overrun, out_valid, out_sample, frame_count);
        end
        $display("ovr_second: ovr=%b sample=%h fc=%0d", overrun, out_sample, frame_count);
        idle(1);
        n_vec++;
        if (overrun !== 1'b0 || out_valid !== 1'b1 || out_sample !== 16'h2000) begin
            n_err++;
            $display("FAIL ovr_pulse: ovr=%b valid=%b sample=%h, required 0 1 2000",
                     overrun, out_valid, out_sample);
        end
    endtask

    task automatic test_gaps_handshake;
        // Sample = voice index; sum 0..255 = 32640, >>>4 = 2040.
        for (int v = 0; v < 255; v++) begin
            beat(8'(v), 16'(v));
            if (v % 7 == 3) idle(1 + v % 3);
        end
        out_ready = 1'b1;
        beat(8'd255, 16'd255);
        n_vec++;
        if (out_valid !== 1'b1 || overrun !== 1'b0 || out_sample !== 16'h07F8 ||
            frame_count !== 16'd3) begin
            n_err++;
            $display("FAIL gaps_done: valid=%b ovr=%b sample=%h fc=%0d, required 1 0 07f8 3",
                     out_valid, overrun, out_sample, frame_count);
        end
        $display("gaps_done: sample=%h ovr=%b", out_sample, overrun);
        idle(1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL gaps_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_midframe;
        out_ready = 1'b0;
        send_frame(16'h0100);
        for (int v = 0; v < 100; v++)
            beat(8'(v), 16'h7FFF);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || frame_count !== 16'd0 || out_sample !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_mid: valid=%b fc=%0d sample=%h, required 0 0 0000",
                     out_valid, frame_count, out_sample);
        end
        // Continuing the old sequence must not complete anything.
        for (int v = 100; v < 256; v++)
            beat(8'(v), 16'h7FFF);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_tail: valid=%b, required 0", out_valid);
        end
        send_frame(16'h0010);
        n_vec++;
        if (out_valid !== 1'b1 || out_sample !== 16'h0100 || frame_count !== 16'd1 ||
            overrun !== 1'b0) begin
            n_err++;
            $display("FAIL rst_clean: valid=%b sample=%h fc=%0d ovr=%b, required 1 0100 1 0",
                     out_valid, out_sample, frame_count, overrun);
        end
        $display("rst_clean: sample=%h fc=%0d", out_sample, frame_count);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sample = 16'h0000;
        in_voice  = 8'd0;
        out_ready = 1'b0;
        #1;
        test_reset;
        test_basic_frame;
        test_saturation;
        test_seq_error;
        test_overrun;
        test_gaps_handshake;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
